// File: rtl/cpu_alu_ctrl_pkg.sv
// cpu_alu_ctrl_pkg: opcode map, FSM encoding and tag width shared by the ALU controller.
// ALU_CTRL_MUL_EN adds the MUL state to the encoding.
package cpu_alu_ctrl_pkg;
  localparam int TAG_W = 5;
  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_SLTU = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_OR   = 3'b111;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
`ifdef ALU_CTRL_MUL_EN
    ST_MUL  = 2'd3,
`endif
    ST_WB   = 2'd2
  } state_t;
  function automatic logic uses_imm(input logic [2:0] op);
    return op == OP_ADDI || op == OP_SUBI;
  endfunction
  // Immediate forms reuse the register add/sub on the external ALU.
  function automatic logic [2:0] alu_op_of(input logic [2:0] op);
    return op == OP_ADDI ? OP_ADD : op == OP_SUBI ? OP_SUB : op;
  endfunction
endpackage

// File: rtl/cpu_alu_ctrl.sv
// cpu_alu_ctrl: sequences one request at a time through an external ALU and holds the result for writeback.
// Define ALU_CTRL_MUL_EN to add a REG_WID-iteration shift-add multiply through the same ALU.
module cpu_alu_ctrl
  import cpu_alu_ctrl_pkg::*;
#(
  parameter int REG_WID = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [REG_WID-1:0] in_a,
  input  logic [REG_WID-1:0] in_b,
  input  logic [REG_WID-1:0] in_imm,
  input  logic               in_mul,
  input  logic [TAG_W-1:0]   in_rd,
  output logic [2:0]         alu_op,
  output logic [REG_WID-1:0] alu_a,
  output logic [REG_WID-1:0] alu_b,
  input  logic [REG_WID-1:0] alu_r,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [TAG_W-1:0]   wb_rd,
  output logic [REG_WID-1:0] wb_data
);
  state_t             r_state;
  logic               r_go;
  logic [2:0]         r_op;
  logic [2:0]         r_alu_op;
  logic [REG_WID-1:0] r_a;
  logic [REG_WID-1:0] r_b;
  logic [REG_WID-1:0] r_imm;
  logic [REG_WID-1:0] r_alu_a;
  logic [REG_WID-1:0] r_alu_b;
  logic [REG_WID-1:0] r_wb_data;
  logic [TAG_W-1:0]   r_wb_rd;
  logic [2:0]         w_op;
  logic [REG_WID-1:0] w_b;
  assign w_op = alu_op_of(r_op);
  assign w_b  = uses_imm(r_op) ? r_imm : r_b;
`ifdef ALU_CTRL_MUL_EN
  localparam int CW = REG_WID > 1 ? $clog2(REG_WID) : 1;
  localparam logic [CW-1:0] LAST = CW'(REG_WID - 1);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;
  assign w_nxt = r_cnt + CW'(1);
`else
  logic w_unused_mul;
  assign w_unused_mul = in_mul;
`endif
  assign in_ready = r_state == ST_IDLE;
  assign wb_valid = r_state == ST_WB;
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign alu_op   = r_alu_op;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  // ALU drive is registered: the first cycle after accept loads it, so the ALU sees it for a full cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_go      <= 1'b0;
      r_op      <= OP_PASS;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_alu_op  <= OP_PASS;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
`ifdef ALU_CTRL_MUL_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_op    <= in_op;
          r_a     <= in_a;
          r_b     <= in_b;
          r_imm   <= in_imm;
          r_wb_rd <= in_rd;
          r_go    <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
          r_cnt   <= '0;
          r_state <= in_mul ? ST_MUL : ST_EXEC;
`else
          r_state <= ST_EXEC;
`endif
        end
        ST_EXEC: if (!r_go) begin
          r_go     <= 1'b1;
          r_alu_op <= w_op;
          r_alu_a  <= r_a;
          r_alu_b  <= w_b;
        end else begin
          r_wb_data <= alu_r;
          r_alu_op  <= OP_PASS;
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_state   <= ST_WB;
        end
`ifdef ALU_CTRL_MUL_EN
        // Iteration i adds A<<i into the accumulator when B[i] is set, else passes it through.
        ST_MUL: if (!r_go) begin
          r_go     <= 1'b1;
          r_alu_op <= r_b[0] ? OP_ADD : OP_PASS;
          r_alu_a  <= '0;
          r_alu_b  <= r_a;
        end else if (r_cnt == LAST) begin
          r_wb_data <= alu_r;
          r_alu_op  <= OP_PASS;
          r_alu_a   <= '0;
          r_alu_b   <= '0;
          r_state   <= ST_WB;
        end else begin
          r_cnt    <= w_nxt;
          r_alu_op <= r_b[w_nxt] ? OP_ADD : OP_PASS;
          r_alu_a  <= alu_r;
          r_alu_b  <= r_a << w_nxt;
        end
`endif
        ST_WB: if (wb_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_alu_ctrl.sv
// tb_cpu_alu_ctrl: directed and random requests against a transaction-level result model,
// with a behavioural external ALU attached to the alu_* ports.
module tb_cpu_alu_ctrl;
  import cpu_alu_ctrl_pkg::*;
  localparam int W = 32;
`ifdef ALU_CTRL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0, in_b = '0, in_imm = '0;
  logic         in_mul = 1'b0;
  logic [4:0]   in_rd = '0;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [4:0]   wb_rd;
  logic [W-1:0] wb_data;
  int checks = 0;
  int errors = 0;

  cpu_alu_ctrl #(.REG_WID(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_mul(in_mul), .in_rd(in_rd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_r = '0;
    case (alu_op)
      OP_PASS: alu_r = alu_a;
      OP_SLTU: alu_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
      OP_ADDI, OP_ADD: alu_r = alu_a + alu_b;
      OP_SUBI, OP_SUB: alu_r = alu_a - alu_b;
      OP_AND:  alu_r = alu_a & alu_b;
      OP_OR:   alu_r = alu_a | alu_b;
      default: alu_r = '0;
    endcase
  end

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, b, imm, input bit mul);
    if (mul && MUL_EN) return a * b;
    case (op)
      OP_PASS: return a;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_ADDI: return a + imm;
      OP_SUBI: return a - imm;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a, b, imm,
                     input bit mul, input logic [4:0] rd, input int hold);
    logic [W-1:0] exp;
    int exp_lat;
    int edges;
    bit saw_ready;
    exp = ref_res(op, a, b, imm, mul);
    exp_lat = (mul && MUL_EN) ? W + 1 : 2;
    edges = 0;
    saw_ready = 1'b0;
    chk({tag, ".idle_ready"}, W'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_imm = imm; in_mul = mul; in_rd = rd;
    wb_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_imm = $urandom;
    in_rd = 5'($urandom); in_mul = 1'($urandom);
    while (!wb_valid && edges < 100) begin
      saw_ready |= in_ready;
      @(posedge clk); #1;
      edges++;
      if (edges == 1 && !(mul && MUL_EN)) begin
        chk({tag, ".alu_op"}, W'(alu_op), W'(uses_imm(op) ? (op == OP_ADDI ? OP_ADD : OP_SUB) : op));
        chk({tag, ".alu_a"}, alu_a, a);
        chk({tag, ".alu_b"}, alu_b, uses_imm(op) ? imm : b);
      end
    end
    chk({tag, ".latency"}, W'(edges), W'(exp_lat));
    chk({tag, ".busy_ready"}, W'(saw_ready | in_ready), 32'd0);
    chk({tag, ".wb_data"}, wb_data, exp);
    chk({tag, ".wb_rd"}, W'(wb_rd), W'(rd));
    chk({tag, ".alu_idle"}, W'(alu_op) | alu_a | alu_b, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, W'(wb_valid), 32'd1);
      chk({tag, ".hold_data"}, wb_data, exp);
      chk({tag, ".hold_ready"}, W'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".done_valid"}, W'(wb_valid), 32'd0);
    chk({tag, ".done_ready"}, W'(in_ready), 32'd1);
  endtask

  task automatic reset_after(input string tag, input int cycles, input bit mul);
    bit saw_valid;
    saw_valid = 1'b0;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd9; in_b = 32'd9; in_mul = mul; in_rd = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk({tag, ".wb_valid"}, W'(wb_valid), 32'd0);
    chk({tag, ".wb_data"}, wb_data, 32'd0);
    chk({tag, ".wb_rd"}, W'(wb_rd), 32'd0);
    chk({tag, ".alu"}, W'(alu_op) | alu_a | alu_b, 32'd0);
    chk({tag, ".in_ready"}, W'(in_ready), 32'd1);
    wb_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      saw_valid |= wb_valid;
    end
    chk({tag, ".no_wb"}, W'(saw_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.in_ready", W'(in_ready), 32'd1);
    chk("reset.wb_valid", W'(wb_valid), 32'd0);
    chk("reset.wb_data", wb_data, 32'd0);
    chk("reset.wb_rd", W'(wb_rd), 32'd0);
    chk("reset.alu", W'(alu_op) | alu_a | alu_b, 32'd0);
    run("add", OP_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 0);
    run("subi", OP_SUBI, 32'd3, 32'd0, 32'd5, 1'b0, 5'd9, 0);
    run("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1, 0);
    run("sltu_t", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd2, 1);
    run("sub_wrap", OP_SUB, 32'd0, 32'd1, 32'd0, 1'b0, 5'd31, 0);
    run("hold", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b0, 5'd17, 4);
    run("mul_req", OP_ADD, 32'd6, 32'd7, 32'd0, 1'b1, 5'd5, 0);
    reset_after("rst_exec", 1, 1'b0);
    run("post_rst", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 1'b0, 5'd11, 0);
    if (MUL_EN) begin
      reset_after("rst_mul", 10, 1'b1);
      run("post_rst_mul", OP_PASS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 5'd12, 1);
    end
    for (int n = 0; n < 40; n++)
      run("rand", 3'($urandom), $urandom, $urandom, $urandom,
          MUL_EN && ($urandom_range(0, 3) == 0), 5'($urandom), int'($urandom_range(0, 2)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
